// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: owns every pipeline-register enable and flush.
// Handles load-use stalls, taken-branch flushes and data-memory waits.
// A data-memory wait that runs too long traps into a sticky error state.
// Keeps saturating event counters.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_RUN      | normal issue; branch and load-use rules evaluated each cycle
// ST_MEM_WAIT | MEM access outstanding; pipeline frozen until dmem_ready_MEM
// ST_ERR      | memory timeout trapped; pipeline frozen until reset
module hazard_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_ID_EX,
  input  logic             mem_read_ID_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready_MEM,
  input  logic             clr_cnt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] ls_cnt_q, ls_cnt_d;
  logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

  logic memhold, loaduse, hold_c, eval_run;
  logic inc_ls, inc_mw, inc_fl;
  logic pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f;

  assign memhold = dmem_req_MEM & ~dmem_ready_MEM;
  assign loaduse = mem_read_ID_EX & (rd_ID_EX != 5'd0) &
                   ((use_rs1_ID & (rs1_ID == rd_ID_EX)) |
                    (use_rs2_ID & (rs2_ID == rd_ID_EX)));

  // Next state, wait timer (down-counter to terminal count 1) and Mealy enables.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    terr_d   = terr_q;
    hold_c   = 1'b0;
    eval_run = 1'b0;
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    idex_w   = 1'b1;
    exmem_w  = 1'b1;
    memwb_w  = 1'b1;
    ifid_f   = 1'b0;
    idex_f   = 1'b0;
    inc_ls   = 1'b0;
    inc_mw   = 1'b0;
    inc_fl   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (memhold) begin
          hold_c  = 1'b1;
          tmr_d   = TMR_W'(MEM_TIMEOUT - 1);
          state_d = (MEM_TIMEOUT == 1) ? ST_ERR : ST_MEM_WAIT;
        end else begin
          eval_run = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready_MEM) begin
          hold_c = 1'b1;
          tmr_d  = tmr_q - TMR_W'(1);
          if (tmr_q == TMR_W'(1)) state_d = ST_ERR;
        end else begin
          eval_run = 1'b1;
          tmr_d    = '0;
          state_d  = ST_RUN;
        end
      end
      default: begin
        pc_w    = 1'b0;
        ifid_w  = 1'b0;
        idex_w  = 1'b0;
        exmem_w = 1'b0;
        memwb_w = 1'b0;
      end
    endcase
    if (hold_c) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      memwb_w = 1'b0;
      inc_mw  = 1'b1;
    end
    if (eval_run) begin
      if (branch_taken_EX) begin
        ifid_f = 1'b1;
        idex_f = 1'b1;
        inc_fl = 1'b1;
      end else if (loaduse) begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_f = 1'b1;
        inc_ls = 1'b1;
      end
    end
    if (state_d == ST_ERR) terr_d = 1'b1;
  end

  // Saturating event counters; clear has priority over increment.
  always_comb begin
    ls_cnt_d = ls_cnt_q;
    mw_cnt_d = mw_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (clr_cnt) begin
      ls_cnt_d = '0;
      mw_cnt_d = '0;
      fl_cnt_d = '0;
    end else begin
      if (inc_ls && ls_cnt_q != '1) ls_cnt_d = ls_cnt_q + CNT_W'(1);
      if (inc_mw && mw_cnt_q != '1) mw_cnt_d = mw_cnt_q + CNT_W'(1);
      if (inc_fl && fl_cnt_q != '1) fl_cnt_d = fl_cnt_q + CNT_W'(1);
    end
  end

  // State, timer, error flag and counters.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_RUN;
      tmr_q    <= '0;
      terr_q   <= 1'b0;
      ls_cnt_q <= '0;
      mw_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      terr_q   <= terr_d;
      ls_cnt_q <= ls_cnt_d;
      mw_cnt_q <= mw_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  // Enables are held off for as long as reset is asserted.
  assign pc_write       = pc_w    & arst_n;
  assign if_id_write    = ifid_w  & arst_n;
  assign id_ex_write    = idex_w  & arst_n;
  assign ex_mem_write   = exmem_w & arst_n;
  assign mem_wb_write   = memwb_w & arst_n;
  assign if_id_flush    = ifid_f  & arst_n;
  assign id_ex_flush    = idex_f  & arst_n;
  assign state          = state_q;
  assign load_stall_cnt = ls_cnt_q;
  assign mem_wait_cnt   = mw_cnt_q;
  assign flush_cnt      = fl_cnt_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized bench for hazard_stall_controller with a cycle-level reference model.
module tb_hazard_stall_controller;

  localparam int CNT_W       = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic [4:0]       rs1_ID = '0, rs2_ID = '0, rd_ID_EX = '0;
  logic             use_rs1_ID = 0, use_rs2_ID = 0, mem_read_ID_EX = 0;
  logic             branch_taken_EX = 0, dmem_req_MEM = 0, dmem_ready_MEM = 1, clr_cnt = 0;
  logic             pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic             if_id_flush, id_ex_flush, timeout_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] load_stall_cnt, mem_wait_cnt, flush_cnt;

  hazard_stall_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .arst_n(arst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_ID_EX(rd_ID_EX), .mem_read_ID_EX(mem_read_ID_EX), .branch_taken_EX(branch_taken_EX),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready_MEM(dmem_ready_MEM), .clr_cnt(clr_cnt),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state(state),
    .load_stall_cnt(load_stall_cnt), .mem_wait_cnt(mem_wait_cnt), .flush_cnt(flush_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 run, 1 waiting, 2 trapped; hold_run counts consecutive holds.
  int m_mode, m_hold_run, m_ls, m_mw, m_fl;
  bit m_terr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic bit is_loaduse();
    return mem_read_ID_EX && rd_ID_EX != 0 &&
           ((use_rs1_ID && rs1_ID == rd_ID_EX) || (use_rs2_ID && rs2_ID == rd_ID_EX));
  endfunction

  function automatic bit is_hold();
    if (m_mode == 0) return dmem_req_MEM && !dmem_ready_MEM;
    if (m_mode == 1) return !dmem_ready_MEM;
    return 1'b0;
  endfunction

  // {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_flush, id_ex_flush}
  function automatic int exp_ctrl();
    if (m_mode == 2 || is_hold()) return 7'b00000_00;
    if (branch_taken_EX)          return 7'b11111_11;
    if (is_loaduse())             return 7'b00111_01;
    return 7'b11111_00;
  endfunction

  function automatic int dut_ctrl();
    return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
            if_id_flush, id_ex_flush};
  endfunction

  task automatic check_all();
    chk("ctrl", dut_ctrl(), exp_ctrl());
    chk("state", state, m_mode);
    chk("load_stall_cnt", load_stall_cnt, m_ls);
    chk("mem_wait_cnt", mem_wait_cnt, m_mw);
    chk("flush_cnt", flush_cnt, m_fl);
    chk("timeout_err", timeout_err, m_terr);
  endtask

  task automatic model_reset();
    m_mode = 0; m_hold_run = 0; m_ls = 0; m_mw = 0; m_fl = 0; m_terr = 0;
  endtask

  task automatic model_clock();
    if (is_hold()) begin
      m_mw       = sat(m_mw);
      m_hold_run = m_hold_run + 1;
      m_mode     = (m_hold_run >= MEM_TIMEOUT) ? 2 : 1;
      if (m_mode == 2) m_terr = 1;
    end else if (m_mode != 2) begin
      if (branch_taken_EX)   m_fl = sat(m_fl);
      else if (is_loaduse()) m_ls = sat(m_ls);
      m_mode     = 0;
      m_hold_run = 0;
    end
    if (clr_cnt) begin
      m_ls = 0; m_mw = 0; m_fl = 0;
    end
  endtask

  task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                      input logic u2, input logic [4:0] rd, input logic mr, input logic br,
                      input logic req, input logic rdy, input logic clr);
    @(negedge clk);
    rs1_ID = r1; rs2_ID = r2; use_rs1_ID = u1; use_rs2_ID = u2; rd_ID_EX = rd;
    mem_read_ID_EX = mr; branch_taken_EX = br; dmem_req_MEM = req;
    dmem_ready_MEM = rdy; clr_cnt = clr;
    #1;
    check_all();
    @(posedge clk);
    model_clock();
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Assert reset away from the clock edge, hold it across an edge, release mid-cycle.
  task automatic pulse_reset();
    @(negedge clk);
    arst_n = 1'b0;
    branch_taken_EX = 1'b1; mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd1; rs1_ID = 5'd1;
    use_rs1_ID = 1'b1;
    #1;
    model_reset();
    chk("reset_ctrl", dut_ctrl(), 0);
    chk("reset_state", state, 0);
    chk("reset_cnts", {load_stall_cnt, mem_wait_cnt, flush_cnt, timeout_err}, 0);
    @(posedge clk);
    #2;
    arst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    pulse_reset();
    // load-use on rs1, then the bubble cycle is free
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    // load to x0, and a match only on the unused rs2
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // branch squashes a simultaneous load-use
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    // three hold cycles then release
    repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    // timeout trap, clr_cnt does not leave ERR
    repeat (4) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) step(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    pulse_reset();
    idle();
    // counter saturation, then clear beats a simultaneous increment
    repeat (5) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    // randomized traffic with occasional mid-operation resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
